// File: rtl/hazard_unit_pkg.sv
// Shared types and helpers for the pipeline hazard unit: forward-select codes,
// memory-FSM states and register-match helpers.
package hazard_unit_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } memState_t;

    // True when a live (written, non-x0) destination feeds either decode source.
    function automatic logic srcMatch(input logic [4:0] rd, input logic we,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
        return we && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

    // Memory-stage result has priority over the older writeback result.
    function automatic logic [1:0] fwdSel(input logic [4:0] rs,
                                          input logic [4:0] rdM, input logic weM,
                                          input logic [4:0] rdW, input logic weW);
        if (weM && (rdM != 5'd0) && (rdM == rs))
            return FWD_M;
        else if (weW && (rdW != 5'd0) && (rdW == rs))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/mem_stall_fsm.sv
// Data-memory handshake FSM: holds the pipeline while an access waits for
// MemAckM, abandons it after MEM_TIMEOUT wait cycles and raises a sticky error.
module mem_stall_fsm
    import hazard_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic memReq,
    input  logic memAck,
    output logic memValid,
    output logic memStall,
    output logic memErr
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    memState_t  state, stateNext;
    logic [7:0] waitCount, countNext;
    logic       errNext;
    logic       stallRaw;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the async clear covers the whole register set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= MEM_IDLE;
            waitCount <= 8'd0;
            memErr    <= 1'b0;
        end else begin
            state     <= stateNext;
            waitCount <= countNext;
            memErr    <= errNext;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        stateNext = state;
        countNext = waitCount;
        errNext   = memErr;
        memValid  = 1'b0;
        stallRaw  = 1'b0;
        case (state)
            MEM_IDLE: begin
                if (memReq) begin
                    memValid = 1'b1;
                    if (!memAck) begin
                        stallRaw  = 1'b1;
                        stateNext = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                memValid = 1'b1;
                if (memAck) begin
                    stateNext = MEM_IDLE;
                    countNext = 8'd0;
                end else if (waitCount == TIMEOUT_CNT) begin
                    errNext   = 1'b1;
                    stateNext = MEM_IDLE;
                    countNext = 8'd0;
                end else begin
                    stallRaw  = 1'b1;
                    countNext = waitCount + 8'd1;
                end
            end
            default: stateNext = MEM_IDLE;
        endcase
    end

    // Stall is masked while reset is held so the rest of the pipeline sees none.
    assign memStall = stallRaw & reset;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use / branch stall-flush and
// memory-wait stalls. Define FORWARDING_EN to enable bypassing; otherwise RAW
// hazards on E/M destinations stall the front end.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        ResultSrcE0,
    input  logic        PCSrcE,
    input  logic        MemReqM,
    input  logic        MemAckM,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        StallW,
    output logic        FlushD,
    output logic        FlushE,
    output logic        MemValidM,
    output logic        MemErr,
    output logic [15:0] StallCount
);

    logic memStall;
    logic loadUse;
    logic dataHaz;
    logic hazStall;

    mem_stall_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_memFsm (
        .clk      (clk),
        .reset    (reset),
        .memReq   (MemReqM),
        .memAck   (MemAckM),
        .memValid (MemValidM),
        .memStall (memStall),
        .memErr   (MemErr)
    );

    assign loadUse = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

`ifdef FORWARDING_EN
    assign ForwardAE = fwdSel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign ForwardBE = fwdSel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    assign dataHaz   = 1'b0;
`else
    // Without bypassing, W-stage results reach decode via regfile write-through.
    assign ForwardAE = FWD_RF;
    assign ForwardBE = FWD_RF;
    assign dataHaz   = srcMatch(RdE, RegWriteE, Rs1D, Rs2D) ||
                       srcMatch(RdM, RegWriteM, Rs1D, Rs2D);
`endif

    assign hazStall = loadUse || dataHaz;

    // A memory wait freezes everything and suppresses flushes; the hazard and
    // branch terms simply re-evaluate once the wait releases.
    assign StallF = memStall || hazStall;
    assign StallD = memStall || hazStall;
    assign StallE = memStall;
    assign StallM = memStall;
    assign StallW = memStall;
    assign FlushD = !memStall && PCSrcE;
    assign FlushE = !memStall && (PCSrcE || hazStall);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            StallCount <= 16'd0;
        else if (StallF && (StallCount != 16'hFFFF))
            StallCount <= StallCount + 16'd1;
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (MEM_TIMEOUT = 4). Expected
// values are hand-computed; forwarding expectations follow FORWARDING_EN.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteE, RegWriteM, RegWriteW;
    logic        ResultSrcE0, PCSrcE, MemReqM, MemAckM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
    logic        MemValidM, MemErr;
    logic [15:0] StallCount;

    int vecCount  = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    hazard_unit #(.MEM_TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .RdM         (RdM),
        .RdW         (RdW),
        .RegWriteE   (RegWriteE),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .ResultSrcE0 (ResultSrcE0),
        .PCSrcE      (PCSrcE),
        .MemReqM     (MemReqM),
        .MemAckM     (MemAckM),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .StallM      (StallM),
        .StallW      (StallW),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .MemValidM   (MemValidM),
        .MemErr      (MemErr),
        .StallCount  (StallCount)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clearInputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0;
        RdE = 0; RdM = 0; RdW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        ResultSrcE0 = 0; PCSrcE = 0; MemReqM = 0; MemAckM = 0;
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic doReset();
        reset = 1'b0;
        clearInputs();
        nextCycle();
        reset = 1'b1;
    endtask

    logic [1:0] expFwdHi, expFwdLo;
    logic       expRawStall;

    initial begin
`ifdef FORWARDING_EN
        expFwdHi    = 2'b10;
        expFwdLo    = 2'b01;
        expRawStall = 1'b0;
`else
        expFwdHi    = 2'b00;
        expFwdLo    = 2'b00;
        expRawStall = 1'b1;
`endif

        // Reset state, with a pending request held during reset
        reset = 1'b0;
        clearInputs();
        MemReqM = 1;
        #2;
        check("rst_stallcnt", StallCount, 0);
        check("rst_memerr",   MemErr, 0);
        check("rst_memvalid", MemValidM, 1);
        check("rst_stallE",   StallE, 0);
        check("rst_stallF",   StallF, 0);
        check("rst_flushD",   FlushD, 0);
        nextCycle();
        MemReqM = 0;
        reset   = 1'b1;
        settle();
        check("idle_memvalid", MemValidM, 0);

        // Forwarding priority
        nextCycle();
        Rs1E = 5; Rs2E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        settle();
        check("fwdA_M", ForwardAE, expFwdHi);
        check("fwdB_M", ForwardBE, expFwdHi);
        RdM = 0;
        settle();
        check("fwdA_W", ForwardAE, expFwdLo);
        RdM = 5; RegWriteM = 0; Rs2E = 6; RdW = 6;
        settle();
        check("fwdA_none", ForwardAE, 2'b00);
        check("fwdB_W",    ForwardBE, expFwdLo);
        RdW = 0;
        settle();
        check("fwdB_x0", ForwardBE, 2'b00);

        // Decode source hitting an M-stage writer; W-stage hit never stalls
        nextCycle();
        clearInputs();
        RdM = 9; RegWriteM = 1; Rs2D = 9;
        settle();
        check("rawM_stallD", StallD, expRawStall);
        check("rawM_flushE", FlushE, expRawStall);
        check("rawM_flushD", FlushD, 0);
        nextCycle();
        clearInputs();
        RdW = 9; RegWriteW = 1; Rs1D = 9;
        settle();
        check("rawW_stallF", StallF, 0);

        // Load-use, then release
        nextCycle();
        clearInputs();
        ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
        settle();
        check("lu_stallF", StallF, 1);
        check("lu_stallD", StallD, 1);
        check("lu_flushE", FlushE, 1);
        check("lu_flushD", FlushD, 0);
        check("lu_stallE", StallE, 0);
        nextCycle();
        ResultSrcE0 = 0;
        settle();
        check("lu_release", StallF, 0);
        RdE = 0; ResultSrcE0 = 1;
        settle();
        check("lu_x0", StallF, 0);

        // Branch alone, and branch with load-use
        nextCycle();
        clearInputs();
        PCSrcE = 1;
        settle();
        check("br_flushD", FlushD, 1);
        check("br_flushE", FlushE, 1);
        check("br_stallF", StallF, 0);
        ResultSrcE0 = 1; RdE = 4; Rs1D = 4;
        settle();
        check("brlu_flushD", FlushD, 1);
        check("brlu_flushE", FlushE, 1);
        check("brlu_stallD", StallD, 1);
        nextCycle();
        clearInputs();
        settle();
        check("cnt_hazard", StallCount, 16'(2 + int'(expRawStall)));

        // Three-cycle memory wait
        doReset();
        settle();
        check("rst_cnt_clear", StallCount, 0);
        MemReqM = 1; MemAckM = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("mw_valid",  MemValidM, 1);
            check("mw_stallF", StallF, 1);
            check("mw_stallE", StallE, 1);
            check("mw_stallW", StallW, 1);
            nextCycle();
        end
        MemAckM = 1;
        settle();
        check("mw_ack_valid", MemValidM, 1);
        check("mw_ack_stall", StallM, 0);
        nextCycle();
        MemReqM = 0; MemAckM = 0;
        settle();
        check("mw_done_valid", MemValidM, 0);
        check("mw_stallcnt",   StallCount, 3);

        // Zero-wait access
        MemReqM = 1; MemAckM = 1;
        settle();
        check("zw_valid", MemValidM, 1);
        check("zw_stall", StallF, 0);
        nextCycle();
        MemReqM = 0; MemAckM = 0;
        settle();
        check("zw_stallcnt", StallCount, 3);

        // Branch during a wait: flush suppressed until the stall drops
        MemReqM = 1; PCSrcE = 1;
        settle();
        check("brw_flushD", FlushD, 0);
        check("brw_flushE", FlushE, 0);
        check("brw_stallD", StallD, 1);
        nextCycle();
        MemAckM = 1;
        settle();
        check("brw_ack_flushD", FlushD, 1);
        check("brw_ack_flushE", FlushE, 1);
        nextCycle();
        MemReqM = 0; MemAckM = 0;
        settle();
        check("brw_after_flushD", FlushD, 1);
        check("brw_after_flushE", FlushE, 1);
        nextCycle();
        clearInputs();
        settle();
        check("brw_stallcnt", StallCount, 4);

        // Timeout: one IDLE stall plus four counting WAIT cycles, then abandon
        MemReqM = 1;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("to_stall", StallF, 1);
            check("to_err_low", MemErr, 0);
            nextCycle();
        end
        settle();
        check("to_stall_drop", StallF, 0);
        check("to_valid", MemValidM, 1);
        nextCycle();
        MemReqM = 0;
        settle();
        check("to_err", MemErr, 1);
        check("to_idle", MemValidM, 0);
        check("to_stallcnt", StallCount, 9);
        for (int i = 0; i < 3; i++) nextCycle();
        settle();
        check("to_err_sticky", MemErr, 1);

        // Asynchronous reset mid-wait
        MemReqM = 1;
        nextCycle();
        nextCycle();
        settle();
        check("arst_pre_stall", StallE, 1);
        reset = 1'b0;
        #1;
        check("arst_err",   MemErr, 0);
        check("arst_cnt",   StallCount, 0);
        check("arst_stallF", StallF, 0);
        check("arst_stallW", StallW, 0);
        MemReqM = 0;
        nextCycle();
        reset = 1'b1;
        nextCycle();
        settle();
        check("arst_valid", MemValidM, 0);
        check("arst_nostall", StallF, 0);

        // E-stage writer feeding decode
        RdE = 3; RegWriteE = 1; Rs1D = 3;
        settle();
        check("rawE_stallD", StallD, expRawStall);
        check("rawE_flushE", FlushE, expRawStall);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: max WAIT cycles before a memory access is abandoned (range 1..255).
REQ-002 SHALL have ports: clk  in  1  clock, rising edge; reset  in  1  asynchronous, active-low.
REQ-003 SHALL have ports: Rs1D, Rs2D  in  5  decode-stage sources; Rs1E, Rs2E  in  5  execute-stage sources.
REQ-004 SHALL have ports: RdE, RdM, RdW  in  5  destinations; RegWriteE, RegWriteM, RegWriteW  in  1  write enables per stage.
REQ-005 SHALL have ports: ResultSrcE0  in  1  load in E; PCSrcE  in  1  taken branch/jump; MemReqM  in  1  load/store in M; MemAckM  in  1  memory done.
REQ-006 SHALL have ports: ForwardAE, ForwardBE  out  2  operand select (00 regfile, 01 W result, 10 M ALU result).
REQ-007 SHALL have ports: StallF, StallD, StallE, StallM, StallW, FlushD, FlushE  out  1 each; MemValidM  out  1  request to data memory.
REQ-008 SHALL have ports: MemErr  out  1  sticky timeout flag; StallCount  out  16  saturating stall-cycle count.

Function
REQ-009 Forwarding SHALL be combinational: ForwardAE=10 if RegWriteM, RdM!=0, RdM==Rs1E; else 01 if RegWriteW, RdW!=0, RdW==Rs1E; else 00. ForwardBE is identical, using Rs2E.
REQ-010 Load-use hazard SHALL be ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D). It SHALL assert StallF, StallD and FlushE.
REQ-011 PCSrcE SHALL assert FlushD and FlushE in the same cycle. PCSrcE together with a load-use hazard SHALL give FlushD=FlushE=1 and StallF=StallD=1.
REQ-012 The memory FSM SHALL have states IDLE and WAIT.
REQ-013 In IDLE with MemReqM: MemValidM=1. MemAckM=1 SHALL keep the FSM in IDLE with no stall (zero-wait). MemAckM=0 SHALL assert memstall and move to WAIT.
REQ-014 In WAIT: MemValidM=1 and memstall=1 until MemAckM=1. On MemAckM=1, memstall SHALL drop combinationally in that cycle and the FSM SHALL return to IDLE.
REQ-015 In WAIT, an 8-bit counter SHALL increment per cycle. When the counter equals MEM_TIMEOUT without ack, the FSM SHALL set MemErr, drop memstall that cycle, go to IDLE and clear the counter.
REQ-016 memstall SHALL assert StallF, StallD, StallE, StallM and StallW, and SHALL force FlushD=FlushE=0. It SHALL override REQ-010/011 in that cycle; those conditions re-evaluate after release.
REQ-017 MemErr SHALL stay 1 until reset.
REQ-018 StallCount SHALL increment on every cycle with StallF=1 and saturate at 16'hFFFF.

Reset
REQ-019 On reset low, the FSM SHALL go to IDLE, and counter, MemErr and StallCount SHALL be cleared, immediately and independent of clk.
REQ-020 Reset mid-WAIT SHALL abandon the access, with MemValidM=0 on the first cycle after release unless MemReqM=1.
REQ-021 Combinational outputs SHALL follow inputs during reset, except that memstall=0.

Configuration
REQ-022 With FORWARDING_EN defined, REQ-009 forwarding SHALL be in effect.
REQ-023 Without FORWARDING_EN: ForwardAE=ForwardBE=00. Any D source matching RdE (RegWriteE) or RdM (RegWriteM), with Rd!=0, SHALL assert StallF, StallD and FlushE. A W-stage match SHALL be resolved by register-file write-through, with no stall.

Structure
REQ-024 A shared package SHALL hold the forward-select constants (FWD_RF, FWD_W, FWD_M) and the FSM state enum (MEM_IDLE, MEM_WAIT).
REQ-025 The memory FSM, timeout counter and MemErr SHALL reside in sub-module mem_stall_fsm. Forwarding and hazard logic SHALL be top-level.

Verification
REQ-026 Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. With RdM=0 -> ForwardAE=01.
REQ-027 ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle, FlushD=0.
REQ-028 MemReqM=1, MemAckM low 3 cycles then high -> MemValidM=1 for 4 cycles, all Stall* =1 for 3 cycles, StallCount=3.
REQ-029 MEM_TIMEOUT=4, MemReqM=1, MemAckM=0 -> after 4 WAIT cycles MemErr=1, stalls drop, FSM IDLE. MemErr SHALL remain 1 until reset.
REQ-030 PCSrcE=1 during WAIT -> FlushD=FlushE=0 while stalled. FlushD=FlushE=1 in the cycle after MemAckM.
REQ-031 Reset low mid-WAIT -> MemErr=0, StallCount=0, Stall* =0 immediately. With FORWARDING_EN undefined, RdE=3, RegWriteE=1, Rs1D=3 -> StallD=1, FlushE=1.
